melody_sequencer: RTL



---
 rtl/melody_pkg.sv | 17 +
 rtl/tone_gen.sv | 32 +++
 rtl/melody_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - sequencer state codes and ROM word field positions
package melody_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_NOTE  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // ROM word is {half_period, duration}; duration sits in the low bits
  localparam int DUR_LSB = 0;

  function automatic int hp_lsb(input int dur_w);
    return DUR_LSB + dur_w;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - half-period counter and toggle flop for the buzzer square wave
module tone_gen #(
  parameter int HP_W = 20
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            en,
  input  logic            clear,
  input  logic [HP_W-1:0] hp,
  output logic            tone
);

  logic [HP_W-1:0] cnt;
  logic            tog;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      cnt <= '0;
      tog <= 1'b0;
    end else if (en && hp != '0) begin
      if (cnt == hp - 1'b1) begin
        cnt <= '0;
        tog <= ~tog;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign tone = en && (hp != '0) && tog;

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - ROM-driven note sequencer with play/stop/pause/loop
// MELODY_GAP_EN adds a silent articulation gap after every note.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int HP_W        = 20,
  parameter int DUR_W       = 8,
  parameter int ADDR_W      = 6,
  parameter int TICK_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 2_500_000
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   play,
  input  logic                   stop,
  input  logic                   pause,
  input  logic                   loop,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [HP_W+DUR_W-1:0]  rom_data,
  output logic                   buzzer,
  output logic                   busy,
  output logic [ADDR_W-1:0]      note_idx,
  output logic                   done
);

  localparam int HP_LSB = hp_lsb(DUR_W);
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [2:0]       state;
  logic [HP_W-1:0]  hp_q;
  logic [DUR_W-1:0] dur_q;
  logic [TW-1:0]    tick_cnt;
  logic [DUR_W-1:0] dur_cnt;
  logic             note_end;
  logic             advance;
  logic             tone_en;
  logic             tone_clear;

  assign note_end = (state == ST_NOTE) && !pause && (tick_cnt == TICK_LAST) &&
                    (dur_cnt == dur_q - 1'b1);

`ifdef MELODY_GAP_EN
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  logic [GW-1:0] gap_cnt;

  assign advance = (state == ST_GAP) && !pause && (gap_cnt == GAP_LAST);

  always_ff @(posedge Clock) begin
    if (!Reset_n || stop || state != ST_GAP) gap_cnt <= '0;
    else if (!pause && !advance)             gap_cnt <= gap_cnt + 1'b1;
  end
`else
  assign advance = note_end;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset_n || stop) begin
      state    <= ST_IDLE;
      rom_addr <= '0;
      note_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hp_q     <= '0;
      dur_q    <= '0;
      tick_cnt <= '0;
      dur_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (play) begin
          state    <= ST_FETCH;
          rom_addr <= '0;
          busy     <= 1'b1;
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          hp_q     <= rom_data[HP_LSB +: HP_W];
          dur_q    <= rom_data[DUR_LSB +: DUR_W];
          tick_cnt <= '0;
          dur_cnt  <= '0;
          if (rom_data[DUR_LSB +: DUR_W] != '0) begin
            state    <= ST_NOTE;
            note_idx <= rom_addr;
          end else if (loop) begin
            rom_addr <= '0;
            state    <= ST_FETCH;
          end else begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            note_idx <= '0;
          end
        end
        ST_NOTE: if (!pause) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (note_end) begin
`ifdef MELODY_GAP_EN
              state <= ST_GAP;
`endif
            end else begin
              dur_cnt <= dur_cnt + 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
`ifdef MELODY_GAP_EN
        ST_GAP: ;
`endif
        default: state <= ST_IDLE;
      endcase
      // The last ROM slot without a marker ends the song unless looping, where the address wraps
      if (advance) begin
        if ((&rom_addr) && !loop) begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          note_idx <= '0;
        end else begin
          rom_addr <= rom_addr + 1'b1;
          state    <= ST_FETCH;
        end
      end
    end
  end

  assign tone_en    = (state == ST_NOTE) && !pause;
  assign tone_clear = (state == ST_LOAD);

  tone_gen #(.HP_W(HP_W)) u_tone (
    .clk    (Clock),
    .resetn (Reset_n),
    .en     (tone_en),
    .clear  (tone_clear),
    .hp     (hp_q),
    .tone   (buzzer)
  );

endmodule
